// File: rtl/vic_wb_n.sv
// vic_wb_n: N-channel vectored interrupt controller for the VM1 bus.
// Optional round-robin arbitration when VIC_ROUND_ROBIN_EN is defined.
module vic_wb_n #(
    parameter int              N          = 2,
    parameter logic [N-1:0]    LEVEL_MASK = '0
) (
    input  logic              clk_sys,
    input  logic              wb_rst_i,
    input  logic              ce,
    input  logic [16*N-1:0]   ivec,
    input  logic [N-1:0]      ireq,
    input  logic [N-1:0]      imask,
    output logic [N-1:0]      iack,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic [15:0]       wb_dat_o,
    output logic              wb_irq_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   prev_q;
    logic [N-1:0]   iack_q, iack_d;
    logic           ack_q, ack_d;
    logic [15:0]    dat_q, dat_d;
    logic           irq_q;
    logic [N-1:0]   elig;
    logic [N-1:0]   clr;
    logic           found;
    logic [PW-1:0]  win;
`ifdef VIC_ROUND_ROBIN_EN
    logic [PW-1:0]  ptr_q, ptr_d;
    int             idx;
`endif

    assign elig = pend_q & ~imask;

    // Later loop iterations override earlier ones, so the last hit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
`ifdef VIC_ROUND_ROBIN_EN
        idx   = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_q) + N - k) % N;
            if (elig[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        dat_d   = dat_q;
        iack_d  = iack_q;
        clr     = '0;
`ifdef VIC_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                iack_d = '0;
                if (wb_stb_i) begin
                    ack_d   = 1'b1;
                    state_d = ACK;
                    if (found) begin
                        dat_d  = ivec[16*win +: 16];
                        iack_d = N'(1) << win;
                        clr    = N'(1) << win;
`ifdef VIC_ROUND_ROBIN_EN
                        ptr_d  = win;
`endif
                    end else begin
                        dat_d = '0;
                    end
                end
            end
            ACK: begin
                iack_d = '0;
                if (!wb_stb_i) begin
                    ack_d   = 1'b0;
                    dat_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
        // A fresh edge beats the service clear so no request is lost.
        for (int i = 0; i < N; i++) begin
            if (LEVEL_MASK[i])
                pend_d[i] = ireq[i] & ~clr[i];
            else
                pend_d[i] = (pend_q[i] & ~clr[i]) | (ireq[i] & ~prev_q[i]);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
            prev_q  <= '0;
            iack_q  <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            irq_q   <= 1'b0;
`ifdef VIC_ROUND_ROBIN_EN
            ptr_q   <= PW'(N - 1);
`endif
        end else if (ce) begin
            state_q <= state_d;
            pend_q  <= pend_d;
            prev_q  <= ireq;
            iack_q  <= iack_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            irq_q   <= |elig;
`ifdef VIC_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign iack     = iack_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign wb_irq_o = irq_q;

endmodule

// File: tb/tb_vic_wb_n.sv
// tb_vic_wb_n: randomized and directed scoreboard bench for vic_wb_n.
// Channels 1 and 3 are level-sensitive, 0 and 2 rising-edge.
module tb_vic_wb_n;

    localparam int           N  = 4;
    localparam logic [N-1:0] LM = 4'b1010;

    logic            clk_sys = 1'b0;
    logic            wb_rst_i, ce, wb_stb_i;
    logic [16*N-1:0] ivec;
    logic [N-1:0]    ireq, imask, iack;
    logic            wb_ack_o, wb_irq_o;
    logic [15:0]     wb_dat_o;

    always #5 clk_sys = ~clk_sys;

    vic_wb_n #(.N(N), .LEVEL_MASK(LM)) dut (
        .clk_sys  (clk_sys),
        .wb_rst_i (wb_rst_i),
        .ce       (ce),
        .ivec     (ivec),
        .ireq     (ireq),
        .imask    (imask),
        .iack     (iack),
        .wb_stb_i (wb_stb_i),
        .wb_ack_o (wb_ack_o),
        .wb_dat_o (wb_dat_o),
        .wb_irq_o (wb_irq_o)
    );

    typedef struct packed {
        logic         ack;
        logic         irq;
        logic [N-1:0] iack;
        logic [15:0]  dat;
    } exp_t;

    typedef struct packed {
        logic [N-1:0] iack;
        logic [15:0]  dat;
    } txn_t;

    exp_t        expq[$];
    txn_t        txq[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] vec[N];

    // Reference model state: a set of pending channels and a bus-busy flag.
    bit          m_pend[N];
    bit          m_prev[N];
    bit          m_busy, m_ack, m_irq;
    logic [15:0] m_dat;
    int          m_served;
    int          m_ptr;

    function automatic int pick(input bit p[N], input logic [N-1:0] mk, input int ptr);
`ifdef VIC_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (ptr - k + N) % N;
            if (p[c] && !mk[c]) return c;
        end
`else
        for (int c = N - 1; c >= 0; c--)
            if (p[c] && !mk[c]) return c;
`endif
        return -1;
    endfunction

    task automatic model_step(input bit c, input bit r, input logic [N-1:0] rq,
                              input logic [N-1:0] mk, input bit s);
        bit   old_ack;
        int   w;
        bit   any;
        exp_t e;
        old_ack = m_ack;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0;
                m_prev[i] = 0;
            end
            m_busy = 0; m_ack = 0; m_irq = 0; m_dat = 0;
            m_served = -1; m_ptr = N - 1;
        end else if (c) begin
            any = 0;
            for (int i = 0; i < N; i++) any |= m_pend[i] && !mk[i];
            m_irq    = any;
            m_served = -1;
            if (!m_busy) begin
                if (s) begin
                    m_busy = 1;
                    m_ack  = 1;
                    w      = pick(m_pend, mk, m_ptr);
                    if (w >= 0) begin
                        m_dat    = vec[w];
                        m_served = w;
                        m_ptr    = w;
                    end else begin
                        m_dat = 0;
                    end
                end
            end else if (!s) begin
                m_busy = 0;
                m_ack  = 0;
                m_dat  = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (LM[i])
                    m_pend[i] = rq[i] && (i != m_served);
                else
                    m_pend[i] = (m_pend[i] && (i != m_served)) || (rq[i] && !m_prev[i]);
                m_prev[i] = rq[i];
            end
        end else begin
            // Held bus: iack must not repeat while ce is low.
            if (m_served >= 0) m_served = m_served;
        end
        e.ack  = m_ack;
        e.irq  = m_irq;
        e.iack = '0;
        if (m_served >= 0) e.iack[m_served] = 1'b1;
        e.dat  = m_dat;
        expq.push_back(e);
        if (m_ack && !old_ack) txq.push_back('{e.iack, e.dat});
    endtask

    task automatic cyc(input bit c, input bit r, input logic [N-1:0] rq,
                       input logic [N-1:0] mk, input bit s);
        ce = c; wb_rst_i = r; ireq = rq; imask = mk; wb_stb_i = s;
        model_step(c, r, rq, mk, s);
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic ack_txn(input logic [N-1:0] rq, input logic [N-1:0] mk);
        for (int i = 0; i < 3; i++) cyc(1, 0, rq, mk, 1);
        for (int i = 0; i < 2; i++) cyc(1, 0, rq, mk, 0);
    endtask

    // Monitor: per-cycle output check plus a vector check on each ack rise.
    logic prev_ack = 1'b0;
    initial forever begin
        exp_t e;
        txn_t t;
        @(posedge clk_sys);
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            tests++;
            if ({wb_ack_o, wb_irq_o, iack, wb_dat_o} !== e) begin
                fails++;
                $display("FAIL cycle@%0t: got ack=%b irq=%b iack=%b dat=%o, want ack=%b irq=%b iack=%b dat=%o",
                         $time, wb_ack_o, wb_irq_o, iack, wb_dat_o, e.ack, e.irq, e.iack, e.dat);
            end
        end
        if (wb_ack_o === 1'b1 && prev_ack !== 1'b1) begin
            tests++;
            if (txq.size() == 0) begin
                fails++;
                $display("FAIL ack_vec@%0t: unexpected ack dat=%o iack=%b, want no ack",
                         $time, wb_dat_o, iack);
            end else begin
                t = txq.pop_front();
                if (wb_dat_o !== t.dat || iack !== t.iack) begin
                    fails++;
                    $display("FAIL ack_vec@%0t: got dat=%o iack=%b, want dat=%o iack=%b",
                             $time, wb_dat_o, iack, t.dat, t.iack);
                end
            end
        end
        prev_ack = wb_ack_o;
    end

    initial begin
        bit           s;
        logic [N-1:0] rq, mk;
        vec[0] = 16'o000274;
        vec[1] = 16'o000060;
        vec[2] = 16'o000110;
        vec[3] = 16'o000330;
        for (int i = 0; i < N; i++) ivec[16*i +: 16] = vec[i];
        ce = 0; wb_rst_i = 1; ireq = 0; imask = 0; wb_stb_i = 0;

        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // Single edge request.
        cyc(1, 0, 4'b0100, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        ack_txn(0, 0);

        // Two edges on the same cycle: higher index first.
        cyc(1, 0, 4'b0101, 0, 0);
        cyc(1, 0, 0, 0, 0);
        ack_txn(0, 0);
        ack_txn(0, 0);

        // Mask the higher channel, then unmask.
        cyc(1, 0, 4'b0101, 4'b0100, 0);
        cyc(1, 0, 0, 4'b0100, 0);
        ack_txn(0, 4'b0100);
        cyc(1, 0, 0, 0, 0);
        ack_txn(0, 0);

        // Request masked before the strobe: empty ack, pending survives.
        cyc(1, 0, 4'b0001, 0, 0);
        cyc(1, 0, 0, 4'b0001, 0);
        ack_txn(0, 4'b0001);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        ack_txn(0, 0);

        // New edge on the channel being serviced.
        cyc(1, 0, 4'b0100, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 4'b0100, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        ack_txn(0, 0);

        // Level channel held: re-pends, then reset mid-ACK with ce low.
        cyc(1, 0, 4'b0010, 0, 0);
        cyc(1, 0, 4'b0010, 0, 0);
        ack_txn(4'b0010, 0);
        cyc(1, 0, 4'b0010, 0, 1);
        cyc(1, 0, 4'b0010, 0, 1);
        cyc(0, 1, 4'b0010, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // ce low freezes everything, including a waiting strobe.
        cyc(1, 0, 4'b0100, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // Two level channels held: order depends on arbitration mode.
        cyc(1, 0, 4'b1000, 0, 0);
        cyc(1, 0, 4'b1000, 0, 0);
        ack_txn(4'b1000, 0);
        cyc(1, 0, 4'b1010, 0, 0);
        for (int i = 0; i < 3; i++) ack_txn(4'b1010, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // Randomized traffic.
        s = 0; rq = 0; mk = 0;
        for (int i = 0; i < 600; i++) begin
            rq = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 7) == 0) mk = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 3) == 0) s = ~s;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, rq, mk, s);
        end
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);

        tests++;
        if (expq.size() != 0 || txq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d cycle and %0d ack entries left, want 0 and 0",
                     expq.size(), txq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vic_wb_n.md
Name: vic_wb_n

Overview:
- Parametrised successor to the two-channel vectored interrupt controller on the VM1 bus.
- Accepts N interrupt request lines and latches them as pending, with per-line edge or level capture.
- Raises the CPU VIRQ when any pending line is not masked.
- During the CPU interrupt-acknowledge read, returns the vector of the winning channel, acks the bus and pulses that channel's iack.
- Adds over the previous block: channel count N, per-channel level/edge mode, a runtime mask input, and an optional round-robin arbitration mode.

Parameters:
- N, 2, number of interrupt channels (1..16).
- LEVEL_MASK, 0, N-bit; bit i=1 makes channel i level-sensitive, 0 makes it rising-edge.

Ports:
- clk_sys  in  1  system clock.
- wb_rst_i  in  1  reset, synchronous to clk_sys, active-high; clears all state.
- ce  in  1  bus clock enable; all sequential updates except reset happen only when ce=1.
- ivec  in  16*N  vectors; channel i is ivec[16*i+15:16*i].
- ireq  in  N  request lines.
- imask  in  N  1 = channel masked; the channel stays pending but is excluded from irq and arbitration.
- iack  out  N  one-ce-cycle pulse on the channel being serviced.
- wb_stb_i  in  1  acknowledge-read strobe (iako & !we & stb).
- wb_ack_o  out  1  reply to the CPU.
- wb_dat_o  out  16  vector returned to the CPU.
- wb_irq_o  out  1  VIRQ to the CPU.

Behaviour:
- Reset: pending=0, ireq history=0, wb_ack_o=0, wb_dat_o=0, iack=0, wb_irq_o=0, state=IDLE, round-robin pointer=N-1.
- Capture, per ce cycle:
  - Edge channel: pending[i] sets when ireq[i]=1 and the previous ce-sampled ireq[i]=0.
  - Level channel: pending[i] follows ireq[i], except during the clear cycle below.
- Eligible set: elig = pending & ~imask.
- wb_irq_o is registered: 1 on the ce cycle after elig≠0; drops the ce cycle after elig becomes 0.
- Default (fixed) priority: highest index wins, so ivec packed as {v60, v274} gives 060 priority over 274.
- State machine, advances on ce only:
  - IDLE: on wb_stb_i=1 and elig≠0, latch winner w; wb_dat_o<=ivec[w]; wb_ack_o<=1; iack[w]<=1; clear pending[w]; go to ACK.
  - IDLE, wb_stb_i=1 and elig=0 (request withdrawn or masked mid-cycle): wb_dat_o<=0; wb_ack_o<=1; no iack; go to ACK. This prevents a bus hang.
  - ACK: iack<=0; wb_dat_o and wb_ack_o hold while wb_stb_i=1. When wb_stb_i=0: wb_ack_o<=0, wb_dat_o<=0, go to IDLE.
  - Handshake latency: stb to ack is 1 ce cycle; ack drops 1 ce cycle after stb drops.
- Simultaneous events:
  - New edge on the channel being cleared: the set wins, so the channel stays pending and a request is never lost.
  - Level channel still asserted after being serviced: re-pends the next ce cycle.
- Winner is frozen while in ACK; changes to ireq or imask do not alter wb_dat_o.
- wb_rst_i mid-ACK: everything returns to reset values on the next clk_sys edge, regardless of ce.
- ce=0 for any duration: all state holds.

Optional Feature:
- Macro: VIC_ROUND_ROBIN_EN.
- Defined:
  - Arbitration starts from the channel just below the last-serviced index (pointer-1) and searches downward with wrap-around.
  - The pointer updates to w on each service and is not changed by the empty-ack path.
- Undefined: fixed highest-index priority; no pointer logic is synthesised.

Test Plan:
- Reset, then N=2, ivec={16'o000060,16'o000274}, pulse ireq[1] -> wb_irq_o=1; stb -> wb_dat_o=16'o000060, wb_ack_o=1 after 1 ce, iack=2'b10 for one ce, wb_irq_o=0 afterwards.
- Pulse ireq[0] and ireq[1] on the same ce -> first ack returns 060, second returns 274, wb_irq_o drops after the second.
- imask=2'b10 with both pending -> first ack returns 274; clear imask -> irq stays high; next ack returns 060.
- ireq[0] pulsed, then imask[0]=1 before stb -> wb_ack_o=1, wb_dat_o=0, no iack pulse, pending[0] remains set.
- LEVEL_MASK=2'b01, ireq[0] held high -> ack returns 274; wb_irq_o re-asserts 1 ce later; wb_rst_i asserted mid-ACK -> wb_ack_o=0 and wb_dat_o=0 next clk.
- VIC_ROUND_ROBIN_EN, N=4, ireq[3] and ireq[1] held level -> service order 3,1,3,1; without the macro -> 3,3,3.
